// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------------+
// | fetch_stage : PC owner, credit-limited imem requests, prefetch queue,     |
// |               registered instruction output to IF/ID. Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_stage #(
  parameter int              PC_W     = 8,
  parameter int              INS_W    = 16,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [INS_W-1:0] ins_out,
  output logic [PC_W-1:0]  ins_pc,
  output logic             ins_valid
);

  // Killed requests can still be in flight while DEPTH live ones are issued.
  localparam int CNT_W = $clog2(2 * DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_resp_pc;
  logic [PC_W-1:0]  r_ins_pc;
  logic [INS_W-1:0] r_ins_out;
  logic             r_ins_valid;
  logic [INS_W-1:0] r_q_ins [DEPTH];
  logic [PC_W-1:0]  r_q_pc  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;

  logic             w_resp;
  logic             w_resp_drop;
  logic             w_resp_live;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic             w_req;
  logic [CNT_W-1:0] w_live;
  logic [CNT_W:0]   w_used;

  assign w_resp      = imem_valid && (r_outstanding != '0);
  assign w_resp_drop = w_resp && (r_drop != '0);
  assign w_resp_live = w_resp && (r_drop == '0);
  assign w_pop       = !redirect && !stall && (r_count != '0);
  assign w_bypass    = !redirect && !stall && (r_count == '0) && w_resp_live;
  assign w_push      = !redirect && w_resp_live && !w_bypass;

  // Credits: queued entries plus live in-flight requests, minus this cycle's pop.
  assign w_live   = r_outstanding - r_drop;
  assign w_used   = {1'b0, r_count} + {1'b0, w_live} - {{CNT_W{1'b0}}, w_pop};
  assign w_req    = rst && !redirect && (w_used < (CNT_W+1)'(DEPTH));

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign ins_out   = r_ins_out;
  assign ins_pc    = r_ins_pc;
  assign ins_valid = r_ins_valid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_ins[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]  <= r_resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_ins_pc      <= '0;
      r_ins_out     <= '0;
      r_ins_valid   <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_req) - CNT_W'(w_resp);
      if (redirect) begin
        // Everything still owed, minus a response landing now, becomes stale.
        r_pc        <= redirect_pc;
        r_resp_pc   <= redirect_pc;
        r_drop      <= r_outstanding - CNT_W'(w_resp);
        r_count     <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_ins_out   <= '0;
        r_ins_valid <= 1'b0;
      end else begin
        r_pc      <= r_pc + PC_W'(w_req);
        r_resp_pc <= r_resp_pc + PC_W'(w_resp_live);
        r_drop    <= r_drop - CNT_W'(w_resp_drop);
        r_count   <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (!stall) begin
          if (w_pop) begin
            r_ins_out   <= r_q_ins[r_rd_ptr];
            r_ins_pc    <= r_q_pc[r_rd_ptr];
            r_ins_valid <= 1'b1;
          end else if (w_bypass) begin
            r_ins_out   <= imem_rdata;
            r_ins_pc    <= r_resp_pc;
            r_ins_valid <= 1'b1;
          end else begin
            r_ins_out   <= '0;
            r_ins_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : directed vectors and corner sequences for fetch_stage.   |
// |                  Rev 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] ins_out;
  logic [7:0]  ins_pc;
  logic        ins_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;

  fetch_stage #(.PC_W(8), .INS_W(16), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .ins_out     (ins_out),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: fixed latency pipeline, mem[a] = 16'hA000 + a.
  logic [3:0] m_v;
  logic [7:0] m_a [4];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v <= '0;
      for (int i = 0; i < 4; i++) m_a[i] <= '0;
    end else begin
      m_v    <= {m_v[2:0], imem_req};
      m_a[0] <= imem_addr;
      m_a[1] <= m_a[0];
      m_a[2] <= m_a[1];
      m_a[3] <= m_a[2];
    end
  end
  assign imem_valid = m_v[lat-1];
  assign imem_rdata = 16'hA000 + {8'h00, m_a[lat-1]};

  typedef struct packed {
    logic        stall;
    logic [15:0] ins;
    logic [7:0]  pc;
    logic        valid;
    logic        req;
    logic [7:0]  addr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assumes caller sits at a sample point; waits bounded for a valid output.
  task automatic wait_valid(input logic [15:0] ei, input logic [7:0] ep, input string nm);
    int n;
    n = 0;
    while (!ins_valid && n < 20) begin
      next_cycle();
      #4;
      n++;
    end
    check({nm, "_valid"}, {31'd0, ins_valid}, 32'd1);
    check({nm, "_ins"}, {16'd0, ins_out}, {16'd0, ei});
    check({nm, "_pc"}, {24'd0, ins_pc}, {24'd0, ep});
  endtask

  task automatic do_reset(input int l);
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    lat         = l;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p;
    vecs[0]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 8'h01};
    vecs[2]  = '{1'b0, 16'hA000, 8'h00, 1'b1, 1'b1, 8'h02};
    vecs[3]  = '{1'b0, 16'hA001, 8'h01, 1'b1, 1'b1, 8'h03};
    vecs[4]  = '{1'b1, 16'hA002, 8'h02, 1'b1, 1'b1, 8'h04};
    vecs[5]  = '{1'b1, 16'hA002, 8'h02, 1'b1, 1'b0, 8'h05};
    vecs[6]  = '{1'b1, 16'hA002, 8'h02, 1'b1, 1'b0, 8'h05};
    vecs[7]  = '{1'b1, 16'hA002, 8'h02, 1'b1, 1'b0, 8'h05};
    vecs[8]  = '{1'b0, 16'hA002, 8'h02, 1'b1, 1'b1, 8'h05};
    vecs[9]  = '{1'b0, 16'hA003, 8'h03, 1'b1, 1'b1, 8'h06};
    vecs[10] = '{1'b0, 16'hA004, 8'h04, 1'b1, 1'b1, 8'h07};
    vecs[11] = '{1'b0, 16'hA005, 8'h05, 1'b1, 1'b1, 8'h08};
    vecs[12] = '{1'b0, 16'hA006, 8'h06, 1'b1, 1'b1, 8'h09};

    do_reset(1);

    // Streaming start, then a 4-cycle stall that fills the queue and drains cleanly.
    for (int i = 0; i < 13; i++) begin
      if (i > 0) next_cycle();
      stall = vecs[i].stall;
      #4;
      check($sformatf("vec%0d_ins", i),   {16'd0, ins_out},   {16'd0, vecs[i].ins});
      check($sformatf("vec%0d_pc", i),    {24'd0, ins_pc},    {24'd0, vecs[i].pc});
      check($sformatf("vec%0d_valid", i), {31'd0, ins_valid}, {31'd0, vecs[i].valid});
      check($sformatf("vec%0d_req", i),   {31'd0, imem_req},  {31'd0, vecs[i].req});
      check($sformatf("vec%0d_addr", i),  {24'd0, imem_addr}, {24'd0, vecs[i].addr});
    end

    // Redirect together with stall: redirect wins.
    next_cycle();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h20;
    #4;
    check("rs_req_blocked", {31'd0, imem_req}, 32'd0);
    next_cycle();
    stall = 1'b0; redirect = 1'b0;
    #4;
    check("rs_bubble_ins", {16'd0, ins_out}, 32'd0);
    check("rs_bubble_valid", {31'd0, ins_valid}, 32'd0);
    check("rs_resume_req", {31'd0, imem_req}, 32'd1);
    check("rs_resume_addr", {24'd0, imem_addr}, 32'h20);
    wait_valid(16'hA020, 8'h20, "rs_first");

    // PC wrap through 8'hFF.
    next_cycle();
    redirect = 1'b1; redirect_pc = 8'hFE;
    #4;
    next_cycle();
    redirect = 1'b0;
    #4;
    wait_valid(16'hA0FE, 8'hFE, "wrap_first");
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      #4;
      p = 8'hFE + 8'(k);
      check($sformatf("wrap%0d_valid", k), {31'd0, ins_valid}, 32'd1);
      check($sformatf("wrap%0d_ins", k), {16'd0, ins_out}, {16'd0, 16'hA000 + {8'h00, p}});
      check($sformatf("wrap%0d_pc", k), {24'd0, ins_pc}, {24'd0, p});
    end

    // Latency 3: redirect while two requests are in flight; stale data must vanish.
    do_reset(3);
    for (int i = 0; i < 6; i++) next_cycle();
    redirect = 1'b1; redirect_pc = 8'h40;
    #4;
    check("l3_redir_req", {31'd0, imem_req}, 32'd0);
    next_cycle();
    redirect = 1'b0;
    #4;
    check("l3_bubble_valid", {31'd0, ins_valid}, 32'd0);
    wait_valid(16'hA040, 8'h40, "l3_first");
    next_cycle();
    #4;
    wait_valid(16'hA041, 8'h41, "l3_second");

    // Asynchronous reset between clock edges.
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    check("arst_ins", {16'd0, ins_out}, 32'd0);
    check("arst_valid", {31'd0, ins_valid}, 32'd0);
    check("arst_pc", {24'd0, ins_pc}, 32'd0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    lat = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #4;
    check("arst_first_req", {31'd0, imem_req}, 32'd1);
    check("arst_first_addr", {24'd0, imem_addr}, 32'h00);
    wait_valid(16'hA000, 8'h00, "arst_first");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
